// File: rtl/wide_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_addsub_seq
// Function : Byte-serial wide add/subtract sequencer driving an 8-bit datapath
// Revision : 1.0 - initial release
// ============================================================================
module wide_addsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  op,
    input  logic                  ci,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic [7:0]            alu_x,
    output logic [7:0]            alu_y,
    output logic                  alu_op,
    output logic                  alu_ci,
    input  logic [7:0]            alu_r,
    input  logic                  alu_of,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   res,
    output logic                  res_co,
    output logic                  res_of,
    output logic                  res_z
);

    localparam int               W        = 8 * NBYTES;
    localparam int               IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            op_q, op_d;
    logic            cb_q, cb_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            zacc_q, zacc_d;
    logic [W-1:0]    res_q, res_d;
    logic            res_co_q, res_co_d;
    logic            res_of_q, res_of_d;
    logic            res_z_q, res_z_d;

    logic [7:0]      w_x_byte;
    logic [7:0]      w_y_byte;
    logic            w_y7_eff;
    logic            w_t7;
    logic            w_co8;
    logic            w_r_zero;

    // Operand byte selected by the current index.
    always_comb begin
        w_x_byte = 8'h00;
        w_y_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == i[IDXW-1:0]) begin
                w_x_byte = a_q[8*i +: 8];
                w_y_byte = b_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        alu_x  = 8'h00;
        alu_y  = 8'h00;
        alu_op = 1'b0;
        alu_ci = 1'b0;
        if (state_q == ST_RUN) begin
            alu_x  = w_x_byte;
            alu_y  = w_y_byte;
            alu_op = op_q;
            alu_ci = cb_q;
        end
    end

    // Recover the carry into bit 7 from the result, then the byte carry-out.
    always_comb begin
        w_y7_eff = w_y_byte[7] ^ op_q;
        w_t7     = w_x_byte[7] ^ w_y7_eff ^ alu_r[7];
        w_co8    = (w_x_byte[7] & w_y7_eff) | (w_x_byte[7] & w_t7) | (w_y7_eff & w_t7);
        w_r_zero = (alu_r == 8'h00);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cb_d     = cb_q;
        idx_d    = idx_q;
        zacc_d   = zacc_q;
        res_d    = res_q;
        res_co_d = res_co_q;
        res_of_d = res_of_q;
        res_z_d  = res_z_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cb_d    = ci;
                    idx_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == i[IDXW-1:0]) begin
                        res_d[8*i +: 8] = alu_r;
                    end
                end
                zacc_d = zacc_q & w_r_zero;
                cb_d   = w_co8 ^ op_q;
                if (idx_q == LAST_IDX) begin
                    res_of_d = alu_of;
                    res_co_d = w_co8 ^ op_q;
                    res_z_d  = zacc_q & w_r_zero;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            cb_q     <= 1'b0;
            idx_q    <= '0;
            zacc_q   <= 1'b0;
            res_q    <= '0;
            res_co_q <= 1'b0;
            res_of_q <= 1'b0;
            res_z_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cb_q     <= cb_d;
            idx_q    <= idx_d;
            zacc_q   <= zacc_d;
            res_q    <= res_d;
            res_co_q <= res_co_d;
            res_of_q <= res_of_d;
            res_z_q  <= res_z_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign res         = res_q;
    assign res_co      = res_co_q;
    assign res_of      = res_of_q;
    assign res_z       = res_z_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_addsub_seq
// Function : Self-checking bench for wide_addsub_seq with an 8-bit datapath model
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_addsub_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic         op;
    logic         ci;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   alu_x;
    logic [7:0]   alu_y;
    logic         alu_op;
    logic         alu_ci;
    logic [7:0]   alu_r;
    logic         alu_of;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res;
    logic         res_co;
    logic         res_of;
    logic         res_z;

    int checks = 0;
    int errors = 0;
    int dp_s;

    wide_addsub_seq #(.NBYTES(NBYTES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .ci          (ci),
        .a           (a),
        .b           (b),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_op      (alu_op),
        .alu_ci      (alu_ci),
        .alu_r       (alu_r),
        .alu_of      (alu_of),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .res_co      (res_co),
        .res_of      (res_of),
        .res_z       (res_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit add/sub datapath sitting downstream of the sequencer.
    always_comb begin
        if (alu_op)
            dp_s = int'($signed(alu_x)) - int'($signed(alu_y)) - int'(alu_ci);
        else
            dp_s = int'($signed(alu_x)) + int'($signed(alu_y)) + int'(alu_ci);
        alu_r  = dp_s[7:0];
        alu_of = (dp_s > 127) || (dp_s < -128);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-word reference computed with plain integer arithmetic.
    task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic opi,
                         input logic cii, output logic [W-1:0] r, output logic co,
                         output logic of, output logic z);
        longint ua, ub, u, s;
        ua = longint'(ai);
        ub = longint'(bi);
        if (opi) begin
            u  = ua - ub - longint'(cii);
            co = (ua < ub + longint'(cii));
            s  = longint'($signed(ai)) - longint'($signed(bi)) - longint'(cii);
        end else begin
            u  = ua + ub + longint'(cii);
            co = u[W];
            s  = longint'($signed(ai)) + longint'($signed(bi)) + longint'(cii);
        end
        r  = u[W-1:0];
        of = (s > (longint'(1) <<< (W-1)) - 1) || (s < -(longint'(1) <<< (W-1)));
        z  = (r == '0);
    endtask

    // Carry (add) or borrow (sub) entering byte i of the wide operation.
    function automatic logic carry_in(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                      input logic opi, input logic cii, input int i);
        longint mask, al, bl, sum;
        mask = (longint'(1) << (8*i)) - 1;
        al   = longint'(ai) & mask;
        bl   = longint'(bi) & mask;
        if (opi) return (al < bl + longint'(cii));
        sum = (al + bl + longint'(cii)) >> (8*i);
        return sum[0];
    endfunction

    // Called on a negedge with the DUT idle; returns on a negedge with it idle.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic opi,
                         input logic cii, input int stall, input int rst_at);
        logic [W-1:0] e_res;
        logic         e_co, e_of, e_z;
        model(ai, bi, opi, cii, e_res, e_co, e_of, e_z);
        start_valid = 1'b1;
        a  = ai;
        b  = bi;
        op = opi;
        ci = cii;
        res_ready = 1'b0;
        #1;
        chk("start_ready_idle", start_ready, 1);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'(($urandom % 2));
        a  = $urandom;
        b  = $urandom;
        op = 1'($urandom % 2);
        ci = 1'($urandom % 2);
        for (int i = 0; i < NBYTES; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_res_valid", res_valid, 0);
                chk("rst_res", res, 0);
                chk("rst_start_ready", start_ready, 1);
                chk("rst_alu_x", alu_x, 0);
                start_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < NBYTES + 2; k++) begin
                    @(negedge clk);
                    chk("post_rst_res_valid", res_valid, 0);
                end
                chk("post_rst_res", res, 0);
                chk("post_rst_idle", start_ready, 1);
                return;
            end
            chk("run_alu_x", alu_x, ai[8*i +: 8]);
            chk("run_alu_y", alu_y, bi[8*i +: 8]);
            chk("run_alu_op", alu_op, opi);
            chk("run_alu_ci", alu_ci, carry_in(ai, bi, opi, cii, i));
            chk("run_res_valid", res_valid, 0);
            chk("run_start_ready", start_ready, 0);
            @(negedge clk);
        end
        chk("done_res_valid", res_valid, 1);
        chk("res", res, e_res);
        chk("res_co", res_co, e_co);
        chk("res_of", res_of, e_of);
        chk("res_z", res_z, e_z);
        start_valid = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_res_valid", res_valid, 1);
            chk("stall_res", res, e_res);
            chk("stall_start_ready", start_ready, 0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("release_res_valid", res_valid, 0);
        chk("release_start_ready", start_ready, 1);
        chk("idle_res_held", res, e_res);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        op          = 1'b0;
        ci          = 1'b0;
        a           = '0;
        b           = '0;
        res_ready   = 1'b0;
        #2;
        chk("reset_start_ready", start_ready, 1);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res", res, 0);
        chk("reset_flags", {res_co, res_of, res_z}, 0);
        chk("reset_alu", {alu_x, alu_y, alu_op, alu_ci}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0, 0, -1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, -1);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, -1);
        do_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 0, -1);
        do_op(32'h0000_0005, 32'h0000_0002, 1'b1, 1'b1, 0, -1);
        do_op(32'h4433_2211, 32'h01F2_E3D4, 1'b0, 1'b1, 0, -1);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 3, -1);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 0, 1);
        do_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom % 6)
                0: rb = ra;
                1: ra = '0;
                2: rb = {W{1'b1}};
                3: ra = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom % 2), 1'($urandom % 2), int'($urandom_range(0, 3)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
